// File: rtl/dekatron_counter_chain.sv
// dekatron_counter_chain: multi-digit one-hot decade counter with two-phase guide pulses and digit-serial carry/borrow.
module dekatron_counter_chain #(
    parameter int DIGITS = 3,
    parameter int SETTLE = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Request,
    input  logic                 Dec,
    input  logic                 Set,
    input  logic [DIGITS*10-1:0] In,
    output logic [DIGITS*10-1:0] Out,
    output logic [DIGITS*4-1:0]  BcdOut,
    output logic                 Ready,
    output logic                 Overflow,
    output logic [DIGITS-1:0]    PulseRight_n,
    output logic [DIGITS-1:0]    PulseLeft_n
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CMAX = CW'(SETTLE - 1);
    typedef enum logic [1:0] {IDLE, PHASE_A, PHASE_B, CARRY} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic dir, dir_n;
    logic [DIGITS*10-1:0] val, val_n, load;
    logic [9:0] cur, rot;
    logic wrap, last_phase;
    logic [DIGITS-1:0] right_n, left_n;
    always_comb begin
        load = '0;
        cur  = '0;
        for (int d = 0; d < DIGITS; d++) begin
            load[d*10 +: 10] = $onehot(In[d*10 +: 10]) ? In[d*10 +: 10] : 10'd1;
            if (idx == IW'(d)) cur = val[d*10 +: 10];
        end
    end
    assign rot = dir ? {cur[0], cur[9:1]} : {cur[8:0], cur[9]};
    // in CARRY, cur already holds the rotated digit, so a wrap shows as landing on 0 (+1) or 9 (-1)
    assign wrap = dir ? cur[9] : cur[0];
    assign last_phase = cnt == CMAX;
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        dir_n   = dir;
        val_n   = val;
        case (state)
            IDLE: begin
                if (Set) val_n = load;
                else if (Request) begin
                    dir_n   = Dec;
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = PHASE_A;
                end
            end
            PHASE_A: begin
                cnt_n   = last_phase ? '0 : cnt + CW'(1);
                state_n = last_phase ? PHASE_B : PHASE_A;
            end
            PHASE_B: begin
                cnt_n   = last_phase ? '0 : cnt + CW'(1);
                state_n = last_phase ? CARRY : PHASE_B;
                for (int d = 0; d < DIGITS; d++)
                    if (last_phase && idx == IW'(d)) val_n[d*10 +: 10] = rot;
            end
            CARRY: begin
                state_n = (wrap && idx != LAST) ? PHASE_A : IDLE;
                idx_n   = (wrap && idx != LAST) ? idx + IW'(1) : idx;
            end
        endcase
    end
    // pulses are computed from the next state so they switch on the same edge as the state
    always_comb begin
        right_n = '1;
        left_n  = '1;
        for (int d = 0; d < DIGITS; d++)
            if ((state_n == PHASE_A || state_n == PHASE_B) && idx_n == IW'(d)) begin
                right_n[d] = (state_n == PHASE_A) == dir_n;
                left_n[d]  = (state_n == PHASE_A) != dir_n;
            end
    end
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            dir          <= 1'b0;
            val          <= {DIGITS{10'd1}};
            PulseRight_n <= '1;
            PulseLeft_n  <= '1;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            cnt          <= cnt_n;
            dir          <= dir_n;
            val          <= val_n;
            PulseRight_n <= right_n;
            PulseLeft_n  <= left_n;
        end
    end
    always_comb begin
        BcdOut = '0;
        for (int d = 0; d < DIGITS; d++)
            for (int k = 0; k < 10; k++)
                if (val[d*10+k]) BcdOut[d*4 +: 4] = 4'(k);
    end
    assign Out      = val;
    assign Ready    = state == IDLE;
    assign Overflow = state == CARRY && wrap && idx == LAST;
endmodule
